program_loader: RTL and testbench

Upstream boot stage for the NBBPU. It receives a byte stream from the serial receiver and assembles 16-bit instruction words. It writes them sequentially into instruction memory and holds the CPU in reset until a complete, checksum-verified program image has been stored. After a good load it releases the CPU, which then fetches from address 0 through its `PC` output.

---
 rtl/program_loader_pkg.sv | 22 ++
 rtl/program_loader_byte_timeout.sv | 31 +++
 rtl/program_loader.sv | 157 +++++++++++++++
 tb/tb_program_loader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: loader states and
// frame field widths.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT_HI,
        ST_COUNT_LO,
        ST_WORD_HI,
        ST_WORD_LO,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } load_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam int COUNT_W = 16;
    localparam int WORD_W  = 16;
    localparam int BYTE_W  = 8;

endpackage

// File: rtl/program_loader_byte_timeout.sv
// Inter-byte idle timer: a down-counter reloaded on every received byte that
// flags expiry once TIMEOUT_CYCLES-1 idle clocks have elapsed while enabled.
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= LOAD_VALUE;
        end else if (clear) begin
            count <= LOAD_VALUE;
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    // A byte in the same cycle always wins over expiry.
    assign expired = enable && !clear && (count == '0);

endmodule

// File: rtl/program_loader.sv
// Boot loader: assembles a framed, XOR-checked byte stream into 16-bit words,
// writes them to instruction memory and holds the CPU in reset until done.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | after reset, waiting for the sync byte
// COUNT_HI | waiting for the word count high byte
// COUNT_LO | waiting for the word count low byte, then range check
// WORD_HI  | waiting for the high byte of the next word
// WORD_LO  | waiting for the low byte; issues the memory write
// CHECK    | waiting for the checksum byte
// DONE     | image verified, CPU released; a new sync restarts
// ERROR    | bad count, checksum or timeout; CPU held; a new sync restarts
module program_loader
    import program_loader_pkg::*;
#(
    parameter int              ADDR_WIDTH     = 8,
    parameter int              TIMEOUT_CYCLES = 1_000_000,
    parameter logic [BYTE_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [BYTE_W-1:0]     rx_byte,
    output logic                  instr_write,
    output logic [ADDR_WIDTH-1:0] instr_address,
    output logic [WORD_W-1:0]     instr_data,
    output logic                  cpu_hold,
    output logic                  loaded,
    output logic                  error
);

    localparam int CW1 = COUNT_W + 1;
    localparam logic [CW1-1:0] MAX_WORDS = CW1'(2 ** ADDR_WIDTH);

    load_state_t state, state_d;

    logic [BYTE_W-1:0]     hi_byte, hi_byte_d;
    logic [BYTE_W-1:0]     checksum, checksum_d;
    logic [COUNT_W-1:0]    remaining, remaining_d;
    logic [ADDR_WIDTH-1:0] address_d;
    logic [WORD_W-1:0]     data_d;
    logic                  write_d, hold_d, loaded_d, error_d;
    logic [COUNT_W-1:0]    word_count;
    logic                  timer_enable, timer_expired;

    assign word_count   = {hi_byte, rx_byte};
    assign timer_enable = state inside {ST_COUNT_HI, ST_COUNT_LO, ST_WORD_HI,
                                        ST_WORD_LO, ST_CHECK};

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_byte_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (rx_valid),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            hi_byte       <= '0;
            checksum      <= '0;
            remaining     <= '0;
            instr_write   <= 1'b0;
            instr_address <= '0;
            instr_data    <= '0;
            cpu_hold      <= 1'b1;
            loaded        <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_d;
            hi_byte       <= hi_byte_d;
            checksum      <= checksum_d;
            remaining     <= remaining_d;
            instr_write   <= write_d;
            instr_address <= address_d;
            instr_data    <= data_d;
            cpu_hold      <= hold_d;
            loaded        <= loaded_d;
            error         <= error_d;
        end
    end

    always_comb begin
        state_d     = state;
        hi_byte_d   = hi_byte;
        checksum_d  = checksum;
        remaining_d = remaining;
        write_d     = 1'b0;
        data_d      = instr_data;
        hold_d      = cpu_hold;
        loaded_d    = loaded;
        error_d     = error;
        // The address advances in the cycle after each write strobe.
        address_d   = instr_write ? instr_address + ADDR_WIDTH'(1) : instr_address;

        if (timer_expired) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
        end else if (rx_valid) begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d    = ST_COUNT_HI;
                        address_d  = '0;
                        checksum_d = '0;
                        loaded_d   = 1'b0;
                        error_d    = 1'b0;
                        hold_d     = 1'b1;
                    end
                end
                ST_COUNT_HI: begin
                    hi_byte_d  = rx_byte;
                    checksum_d = checksum ^ rx_byte;
                    state_d    = ST_COUNT_LO;
                end
                ST_COUNT_LO: begin
                    checksum_d  = checksum ^ rx_byte;
                    remaining_d = word_count;
                    if ((word_count == '0) || ({1'b0, word_count} > MAX_WORDS)) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_WORD_HI;
                    end
                end
                ST_WORD_HI: begin
                    hi_byte_d  = rx_byte;
                    checksum_d = checksum ^ rx_byte;
                    state_d    = ST_WORD_LO;
                end
                ST_WORD_LO: begin
                    checksum_d  = checksum ^ rx_byte;
                    write_d     = 1'b1;
                    data_d      = word_count;
                    remaining_d = remaining - COUNT_W'(1);
                    state_d     = (remaining == COUNT_W'(1)) ? ST_CHECK : ST_WORD_HI;
                end
                ST_CHECK: begin
                    if (rx_byte == checksum) begin
                        state_d  = ST_DONE;
                        loaded_d = 1'b1;
                        hold_d   = 1'b0;
                    end else begin
                        state_d  = ST_ERROR;
                        error_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad loads, count bounds, timeout,
// mid-frame reset and back-to-back bytes with leading noise.
module tb_program_loader;

    localparam int AW = 8;
    localparam int TO = 16;

    logic          clock    = 1'b0;
    logic          reset    = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte  = 8'h00;
    logic          instr_write;
    logic [AW-1:0] instr_address;
    logic [15:0]   instr_data;
    logic          cpu_hold;
    logic          loaded;
    logic          error;

    int n_checks = 0;
    int n_errors = 0;

    program_loader #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .instr_write  (instr_write),
        .instr_address(instr_address),
        .instr_data   (instr_data),
        .cpu_hold     (cpu_hold),
        .loaded       (loaded),
        .error        (error)
    );

    always #5 clock = ~clock;

    // Write log sampled on the falling edge, plus a check that strobes never stretch.
    logic [AW-1:0] log_addr [0:63];
    logic [15:0]   log_data [0:63];
    int            wr_count  = 0;
    int            pulse_err = 0;
    logic          prev_wr   = 1'b0;

    always @(negedge clock) begin
        if (instr_write === 1'b1) begin
            if (wr_count < 64) begin
                log_addr[wr_count] = instr_address;
                log_data[wr_count] = instr_data;
            end
            wr_count = wr_count + 1;
            if (prev_wr) pulse_err = pulse_err + 1;
        end
        prev_wr = (instr_write === 1'b1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        idle(3);
        check_eq("rst_write",   instr_write,   0);
        check_eq("rst_address", instr_address, 0);
        check_eq("rst_data",    instr_data,    0);
        check_eq("rst_hold",    cpu_hold,      1);
        check_eq("rst_loaded",  loaded,        0);
        check_eq("rst_error",   error,         0);
        reset = 1'b1;
        idle(2);

        // Good load; checksum is the XOR of count and word bytes = 0x42.
        base = wr_count;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        check_eq("w0_strobe",  instr_write,   1);
        check_eq("w0_address", instr_address, 0);
        check_eq("w0_data",    instr_data,    16'h1234);
        check_eq("w0_hold",    cpu_hold,      1);
        send_byte(8'hAB);
        check_eq("w0_strobe_end", instr_write,   0);
        check_eq("addr_incr",     instr_address, 1);
        send_byte(8'hCD);
        check_eq("w1_strobe",  instr_write,   1);
        check_eq("w1_address", instr_address, 1);
        check_eq("w1_data",    instr_data,    16'hABCD);
        send_byte(8'h42);
        check_eq("good_hold",   cpu_hold, 0);
        check_eq("good_loaded", loaded,   1);
        check_eq("good_error",  error,    0);
        idle(2);
        check_eq("good_nwrites", wr_count - base, 2);
        check_eq("good_log0_a",  log_addr[base],   0);
        check_eq("good_log0_d",  log_data[base],   16'h1234);
        check_eq("good_log1_a",  log_addr[base+1], 1);
        check_eq("good_log1_d",  log_data[base+1], 16'hABCD);

        // Reload after DONE, then a bad checksum.
        base = wr_count;
        send_byte(8'hA5);
        check_eq("reload_hold",   cpu_hold, 1);
        check_eq("reload_loaded", loaded,   0);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h41);
        check_eq("badck_error",  error,    1);
        check_eq("badck_hold",   cpu_hold, 1);
        check_eq("badck_loaded", loaded,   0);
        idle(2);
        check_eq("badck_nwrites", wr_count - base, 2);

        // Count of zero.
        send_byte(8'hA5);
        check_eq("n0_error_clr", error, 0);
        send_byte(8'h00); send_byte(8'h00);
        check_eq("n0_error", error, 1);

        // Count of 257 exceeds a 256-word memory.
        base = wr_count;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        check_eq("n257_error", error, 1);
        send_byte(8'h12); send_byte(8'h34);
        idle(3);
        check_eq("n257_nwrites", wr_count - base, 0);

        // Count of exactly 256 is accepted; the stalled frame then times out.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        check_eq("n256_accept", error, 0);
        idle(20);
        check_eq("n256_timeout", error, 1);

        // Timeout 16 cycles after the last byte.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
        idle(15);
        check_eq("tmo_early", error, 0);
        idle(1);
        check_eq("tmo_error", error,    1);
        check_eq("tmo_hold",  cpu_hold, 1);

        // Asynchronous reset while a write strobe is active.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mrst_write",   instr_write,   0);
        check_eq("mrst_address", instr_address, 0);
        check_eq("mrst_data",    instr_data,    0);
        check_eq("mrst_hold",    cpu_hold,      1);
        check_eq("mrst_loaded",  loaded,        0);
        check_eq("mrst_error",   error,         0);
        @(negedge clock);
        reset = 1'b1;
        idle(2);

        // Noise in IDLE, then a back-to-back frame whose data contains the sync byte.
        send_byte(8'h00); send_byte(8'hFF);
        check_eq("noise_error",  error,    0);
        check_eq("noise_loaded", loaded,   0);
        check_eq("noise_hold",   cpu_hold, 1);
        base = wr_count;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'hA5); send_byte(8'hA5);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hFF); send_byte(8'hEE);
        send_byte(8'h13);
        check_eq("b2b_loaded", loaded,   1);
        check_eq("b2b_hold",   cpu_hold, 0);
        idle(2);
        check_eq("b2b_nwrites", wr_count - base, 3);
        check_eq("b2b_log0_a",  log_addr[base],   0);
        check_eq("b2b_log0_d",  log_data[base],   16'hA5A5);
        check_eq("b2b_log1_a",  log_addr[base+1], 1);
        check_eq("b2b_log1_d",  log_data[base+1], 16'h0001);
        check_eq("b2b_log2_a",  log_addr[base+2], 2);
        check_eq("b2b_log2_d",  log_data[base+2], 16'hFFEE);

        check_eq("strobe_width", pulse_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
